memory_access_stage: RTL
========================

# memory_access_stage

Memory (MEM) stage of the uDLX pipeline. It consumes the registered execute-stage outputs (access enables, address, store data, write-back control), drives the data-memory request/acknowledge bus, and stalls the upstream pipe while an access is outstanding. It ends in the MEM/WB pipeline register that feeds write-back, selecting load data or ALU data. A wait-cycle watchdog aborts accesses that are never acknowledged.

## Interface
- DATA_WIDTH, 32, data path width
- ADDR_WIDTH, 20, data-memory address width; the address is alu_data_in[ADDR_WIDTH-1:0]
- REG_ADDR_WIDTH, 5, register-file address width
- MAX_WAIT, 15, maximum WAIT cycles before abort; must be at least 1
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  kill the instruction at the stage input; honoured only in IDLE
- mem_data_rd_en_in  in  1  load request
- mem_data_wr_en_in  in  1  store request
- mem_data_in  in  DATA_WIDTH  store data
- alu_data_in  in  DATA_WIDTH  ALU result, also the memory address
- reg_wr_en_in  in  1  register write enable
- reg_wr_addr_in  in  REG_ADDR_WIDTH  destination register
- write_back_mux_sel_in  in  1  write-back source: 1 = load data, 0 = ALU data
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  ADDR_WIDTH  memory address
- dmem_wdata  out  DATA_WIDTH  write data
- dmem_rdata  in  DATA_WIDTH  read data, valid in the ack cycle
- dmem_ack  in  1  access complete
- stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM
- reg_wr_en_out  out  1  MEM/WB register write enable
- reg_wr_addr_out  out  REG_ADDR_WIDTH  MEM/WB destination register
- wb_data_out  out  DATA_WIDTH  MEM/WB write-back data
- mem_error_out  out  1  one-cycle pulse on watchdog abort

## Operation
- Terms: `access` = rd_en_in | wr_en_in. `ack_ok` = state WAIT and dmem_ack.
- FSM states are IDLE and WAIT.
- IDLE with flush:
  - MEM/WB takes a bubble: reg_wr_en_out=0, reg_wr_addr_out=0, wb_data_out=0.
  - No request is issued.
- IDLE without access:
  - MEM/WB takes reg_wr_en_in and reg_wr_addr_in.
  - wb_data_out takes alu_data_in.
- IDLE with access and no flush:
  - The next state is WAIT.
  - The block latches dmem_we=wr_en_in, dmem_addr, dmem_wdata=mem_data_in, and the write-back controls.
  - dmem_req=1 from the next cycle.
  - MEM/WB takes a bubble this cycle.
- When rd_en and wr_en are both 1, the store wins and dmem_we=1.
- WAIT:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until the ack cycle, inclusive.
  - flush is ignored.
  - The watchdog counts WAIT cycles.
- WAIT with dmem_ack:
  - The next state is IDLE and dmem_req drops.
  - MEM/WB takes the latched reg_wr_en and reg_wr_addr.
  - wb_data_out = dmem_rdata if the latched sel is 1, otherwise the latched ALU data.
  - This applies to stores too; the latched controls decide the write-back.
- WAIT with the count at MAX_WAIT and no ack:
  - The access is aborted and dmem_req drops.
  - mem_error_out=1 for one cycle.
  - MEM/WB takes a bubble and the next state is IDLE.
- dmem_ack and timeout in the same cycle: the ack wins.
- dmem_ack while dmem_req=0 is ignored.
- stall = (IDLE and access and not flush) or (WAIT and not dmem_ack).
  - While stalled, upstream holds its inputs stable.

## Timing
- Reset: state IDLE, watchdog counter 0, and every registered output 0.
  - This covers dmem_req, dmem_we, dmem_addr, dmem_wdata, reg_wr_en_out, reg_wr_addr_out, wb_data_out and mem_error_out.
  - stall reads 0 when the inputs are idle.
- Non-memory instruction: 1 cycle from input to MEM/WB, no stall.
- Memory access: the request appears 1 cycle after the input.
  - MEM/WB updates at the edge ending the ack cycle.
  - Minimum latency is 2 cycles, for an ack in the first WAIT cycle.
  - Stall lasts 1 + (number of WAIT cycles without ack).
- Abort: mem_error_out pulses in the cycle after the MAX_WAIT-th WAIT cycle.
  - dmem_req is 0 in that cycle.
- Reset mid-access: req drops at once and the FSM returns to IDLE.
- Back-to-back accesses: one IDLE cycle between acks, so dmem_req is low for at least 1 cycle.
- The counter is 4 bits for the default MAX_WAIT.

## Test plan
- Reset, then an ALU op (alu_data_in=0x0000_1234, reg 5, wr_en 1) -> next cycle: reg_wr_en_out=1, reg_wr_addr_out=5, wb_data_out=0x1234, stall=0.
- Load, addr 0x00040, sel=1, reg 7, ack in the 3rd WAIT cycle with rdata=0xDEADBEEF:
  - stall is high for 3 cycles.
  - wb_data_out=0xDEADBEEF and reg_wr_addr_out=7 after the ack edge.
- Store, wdata=0xCAFE0001, addr 0x00100, immediate ack:
  - dmem_we=1, dmem_wdata=0xCAFE0001, dmem_addr=0x00100.
  - The request lasts exactly 1 cycle and stall lasts 1 cycle.
- No ack for MAX_WAIT=15 cycles -> mem_error_out is a 1-cycle pulse, req drops, MEM/WB bubble, stall released.
  - Repeat with the ack arriving exactly in the 15th WAIT cycle -> normal completion and no error.
- flush with a load in IDLE -> no dmem_req, bubble, stall=0.
  - flush asserted during WAIT -> ignored; the access completes and writes back.
- rst_n low in WAIT -> all outputs 0 immediately.
  - A later access after reset completes normally.

Source files
------------

// File: rtl/memory_access_stage_if.sv
// -----------------------------------------------------------------------------
// memory_access_stage_if
// Data-memory request/acknowledge bus between the uDLX MEM stage and the data
// memory.
//   dmem_req   : access request, held until the acknowledge cycle
//   dmem_we    : 1 = write, 0 = read
//   dmem_addr  : word address
//   dmem_wdata : store data
//   dmem_rdata : load data, valid in the acknowledge cycle
//   dmem_ack   : access complete
// Modports: master = pipeline stage, slave = memory.
// -----------------------------------------------------------------------------
interface memory_access_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic [DATA_WIDTH-1:0] dmem_rdata;
  logic                  dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage
// MEM stage of the uDLX pipeline. Issues loads/stores on the data-memory bus,
// stalls upstream while an access is outstanding, aborts accesses that are
// never acknowledged (watchdog), and ends in the MEM/WB pipeline register.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   flush                       : kill the instruction at the input (IDLE only)
//   mem_data_rd_en_in/_wr_en_in : load / store request
//   mem_data_in                 : store data
//   alu_data_in                 : ALU result, low ADDR_WIDTH bits = address
//   reg_wr_en_in/reg_wr_addr_in : write-back control
//   write_back_mux_sel_in       : 1 = load data, 0 = ALU data
//   dmem                        : data-memory bus (master side)
//   stall                       : combinational upstream freeze
//   reg_wr_en_out/reg_wr_addr_out/wb_data_out : MEM/WB register
//   mem_error_out               : one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module memory_access_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 20,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_WAIT       = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      mem_data_rd_en_in,
  input  logic                      mem_data_wr_en_in,
  input  logic [DATA_WIDTH-1:0]     mem_data_in,
  input  logic [DATA_WIDTH-1:0]     alu_data_in,
  input  logic                      reg_wr_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
  input  logic                      write_back_mux_sel_in,
  memory_access_stage_if.master     dmem,
  output logic                      stall,
  output logic                      reg_wr_en_out,
  output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
  output logic [DATA_WIDTH-1:0]     wb_data_out,
  output logic                      mem_error_out
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  // Counter holds the index (1-based) of the current WAIT cycle.
  localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_e                    state_q;
  logic [CNT_W-1:0]          wait_cnt_q;
  logic [CNT_W-1:0]          wait_cnt_d;

  logic                      dmem_req_q;
  logic                      dmem_we_q;
  logic [ADDR_WIDTH-1:0]     dmem_addr_q;
  logic [DATA_WIDTH-1:0]     dmem_wdata_q;

  // Write-back controls of the instruction that owns the outstanding access.
  logic                      lat_reg_wr_en_q;
  logic [REG_ADDR_WIDTH-1:0] lat_reg_wr_addr_q;
  logic                      lat_sel_q;
  logic [DATA_WIDTH-1:0]     lat_alu_q;

  logic                      reg_wr_en_q;
  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_q;
  logic [DATA_WIDTH-1:0]     wb_data_q;
  logic                      mem_error_q;

  logic                      access;
  logic                      ack_ok;
  logic                      timeout;

  assign access     = mem_data_rd_en_in | mem_data_wr_en_in;
  // An ack outside WAIT has no request behind it and is ignored.
  assign ack_ok     = (state_q == S_WAIT) && dmem.dmem_ack;
  // Ack has priority over the watchdog in the same cycle.
  assign timeout    = (state_q == S_WAIT) && !dmem.dmem_ack && (wait_cnt_q == CNT_MAX);
  assign wait_cnt_d = wait_cnt_q + CNT_ONE;

  assign stall = ((state_q == S_IDLE) && access && !flush) ||
                 ((state_q == S_WAIT) && !dmem.dmem_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      wait_cnt_q        <= '0;
      dmem_req_q        <= 1'b0;
      dmem_we_q         <= 1'b0;
      dmem_addr_q       <= '0;
      dmem_wdata_q      <= '0;
      lat_reg_wr_en_q   <= 1'b0;
      lat_reg_wr_addr_q <= '0;
      lat_sel_q         <= 1'b0;
      lat_alu_q         <= '0;
      reg_wr_en_q       <= 1'b0;
      reg_wr_addr_q     <= '0;
      wb_data_q         <= '0;
      mem_error_q       <= 1'b0;
    end else begin
      mem_error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (flush) begin
            reg_wr_en_q   <= 1'b0;
            reg_wr_addr_q <= '0;
            wb_data_q     <= '0;
          end else if (access) begin
            state_q           <= S_WAIT;
            wait_cnt_q        <= CNT_ONE;
            dmem_req_q        <= 1'b1;
            // A simultaneous load and store resolves to the store.
            dmem_we_q         <= mem_data_wr_en_in;
            dmem_addr_q       <= alu_data_in[ADDR_WIDTH-1:0];
            dmem_wdata_q      <= mem_data_in;
            lat_reg_wr_en_q   <= reg_wr_en_in;
            lat_reg_wr_addr_q <= reg_wr_addr_in;
            lat_sel_q         <= write_back_mux_sel_in;
            lat_alu_q         <= alu_data_in;
            reg_wr_en_q       <= 1'b0;
            reg_wr_addr_q     <= '0;
            wb_data_q         <= '0;
          end else begin
            reg_wr_en_q   <= reg_wr_en_in;
            reg_wr_addr_q <= reg_wr_addr_in;
            wb_data_q     <= alu_data_in;
          end
        end
        S_WAIT: begin
          if (ack_ok) begin
            state_q       <= S_IDLE;
            dmem_req_q    <= 1'b0;
            reg_wr_en_q   <= lat_reg_wr_en_q;
            reg_wr_addr_q <= lat_reg_wr_addr_q;
            wb_data_q     <= lat_sel_q ? dmem.dmem_rdata : lat_alu_q;
          end else if (timeout) begin
            state_q       <= S_IDLE;
            dmem_req_q    <= 1'b0;
            mem_error_q   <= 1'b1;
            reg_wr_en_q   <= 1'b0;
            reg_wr_addr_q <= '0;
            wb_data_q     <= '0;
          end else begin
            // Instruction still in flight: nothing reaches write-back yet.
            wait_cnt_q    <= wait_cnt_d;
            reg_wr_en_q   <= 1'b0;
            reg_wr_addr_q <= '0;
            wb_data_q     <= '0;
          end
        end
      endcase
    end
  end

  assign dmem.dmem_req   = dmem_req_q;
  assign dmem.dmem_we    = dmem_we_q;
  assign dmem.dmem_addr  = dmem_addr_q;
  assign dmem.dmem_wdata = dmem_wdata_q;

  assign reg_wr_en_out   = reg_wr_en_q;
  assign reg_wr_addr_out = reg_wr_addr_q;
  assign wb_data_out     = wb_data_q;
  assign mem_error_out   = mem_error_q;

endmodule
